// File: rtl/rename_dispatch_stage_pkg.sv
// Shared types and defaults for the rename/dispatch stage.
// Contents: default widths, the CDB broadcast record (cdb_t) and a
// saturating 32-bit increment used by the optional performance counters.
package rename_dispatch_stage_pkg;

   localparam int XLEN_DEF      = 32;
   localparam int ROB_IDX_W_DEF = 4;
   localparam int NUM_CDB_DEF   = 4;
   localparam int NUM_RS_DEF    = 4;
   localparam int CTRL_W_DEF    = 32;

   typedef struct packed {
      logic                     valid;
      logic [ROB_IDX_W_DEF-1:0] tag;
      logic [XLEN_DEF-1:0]      value;
   } cdb_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/rename_dispatch_stage_if.sv
// Dispatch bus between the rename stage and the reservation stations.
// master (stage): drives rs_dispatch and the staged payload, reads rs_full.
// slave  (RS):    drives rs_full, reads the strobe and payload.
interface rename_dispatch_stage_if #(
   parameter int XLEN      = 32,
   parameter int ROB_IDX_W = 4,
   parameter int NUM_RS    = 4,
   parameter int CTRL_W    = 32
);
   logic [NUM_RS-1:0]    rs_full;
   logic [NUM_RS-1:0]    rs_dispatch;
   logic [XLEN-1:0]      d_pc;
   logic [XLEN-1:0]      d_imm;
   logic [CTRL_W-1:0]    d_ctrl;
   logic [ROB_IDX_W-1:0] d_rob_tag;
   logic [4:0]           d_rd;
   logic [XLEN-1:0]      d_r1_v;
   logic [XLEN-1:0]      d_r2_v;
   logic                 d_r1_busy;
   logic                 d_r2_busy;
   logic [ROB_IDX_W-1:0] d_r1_tag;
   logic [ROB_IDX_W-1:0] d_r2_tag;

   modport master (
      input  rs_full,
      output rs_dispatch, d_pc, d_imm, d_ctrl, d_rob_tag, d_rd,
             d_r1_v, d_r2_v, d_r1_busy, d_r2_busy, d_r1_tag, d_r2_tag
   );

   modport slave (
      output rs_full,
      input  rs_dispatch, d_pc, d_imm, d_ctrl, d_rob_tag, d_rd,
             d_r1_v, d_r2_v, d_r1_busy, d_r2_busy, d_r1_tag, d_r2_tag
   );
endinterface

// File: rtl/rename_dispatch_stage_cdb_match.sv
// Looks up one ROB tag against all CDB broadcast ports.
// Ports: tag in; cdb_valid/cdb_tag/cdb_value flattened broadcast bus in;
// hit/value out. When several ports match, the lowest index wins.
module rename_dispatch_stage_cdb_match #(
   parameter int XLEN      = 32,
   parameter int ROB_IDX_W = 4,
   parameter int NUM_CDB   = 4
) (
   input  logic [ROB_IDX_W-1:0]         tag,
   input  logic [NUM_CDB-1:0]           cdb_valid,
   input  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_tag,
   input  logic [NUM_CDB*XLEN-1:0]      cdb_value,
   output logic                         hit,
   output logic [XLEN-1:0]              value
);
   // Scan high to low so the lowest matching port overwrites last.
   always_comb begin
      hit   = 1'b0;
      value = '0;
      for (int i = NUM_CDB - 1; i >= 0; i--) begin
         if (cdb_valid[i] && (cdb_tag[i*ROB_IDX_W +: ROB_IDX_W] == tag)) begin
            hit   = 1'b1;
            value = cdb_value[i*XLEN +: XLEN];
         end
      end
   end
endmodule

// File: rtl/rename_dispatch_stage.sv
// Rename/dispatch stage: renames one decoded instruction per cycle against
// the regfile, ROB and CDB, holds it in a one-entry staging register that
// keeps snooping the CDB, and dispatches it to a one-hot selected RS.
// Ports: clk, rst (sync, active-high); flush; decode handshake in_*;
// regfile read rf_*; ROB read/alloc rob_*; rename-table write rf_ren_*;
// CDB cdb_*; dispatch bus via rename_dispatch_stage_if.master (disp).
// Optional: define DISPATCH_PERF_EN to add perf_dispatched, perf_stall_rob
// and perf_stall_rs saturating counters.
module rename_dispatch_stage
   import rename_dispatch_stage_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int ROB_IDX_W = ROB_IDX_W_DEF,
   parameter int NUM_CDB   = NUM_CDB_DEF,
   parameter int NUM_RS    = NUM_RS_DEF,
   parameter int CTRL_W    = CTRL_W_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [XLEN-1:0]              in_pc,
   input  logic [XLEN-1:0]              in_imm,
   input  logic [CTRL_W-1:0]            in_ctrl,
   input  logic [NUM_RS-1:0]            in_fu_sel,
   input  logic [4:0]                   in_rd,
   input  logic                         in_rd_we,
   input  logic [4:0]                   in_rs1,
   input  logic [4:0]                   in_rs2,
   input  logic                         in_rs1_use,
   input  logic                         in_rs2_use,
   input  logic [XLEN-1:0]              in_op1_alt,
   input  logic [XLEN-1:0]              in_op2_alt,
   input  logic [XLEN-1:0]              rf_r1_v,
   input  logic [XLEN-1:0]              rf_r2_v,
   input  logic                         rf_r1_ready,
   input  logic                         rf_r2_ready,
   input  logic [ROB_IDX_W-1:0]         rf_r1_tag,
   input  logic [ROB_IDX_W-1:0]         rf_r2_tag,
   input  logic [XLEN-1:0]              rob_r1_v,
   input  logic [XLEN-1:0]              rob_r2_v,
   input  logic                         rob_r1_ready,
   input  logic                         rob_r2_ready,
   input  logic                         rob_full,
   input  logic [ROB_IDX_W-1:0]         rob_alloc_tag,
   output logic                         rob_alloc,
   output logic                         rf_ren_we,
   output logic [4:0]                   rf_ren_rd,
   output logic [ROB_IDX_W-1:0]         rf_ren_tag,
   input  logic [NUM_CDB-1:0]           cdb_valid,
   input  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_tag,
   input  logic [NUM_CDB*XLEN-1:0]      cdb_value,
   rename_dispatch_stage_if.master      disp
`ifdef DISPATCH_PERF_EN
   ,
   output logic [31:0]                  perf_dispatched,
   output logic [31:0]                  perf_stall_rob,
   output logic [31:0]                  perf_stall_rs
`endif
);

   logic                 stage_valid;
   logic [XLEN-1:0]      s_pc, s_imm, s_r1_v, s_r2_v;
   logic [CTRL_W-1:0]    s_ctrl;
   logic [NUM_RS-1:0]    s_sel;
   logic [ROB_IDX_W-1:0] s_rob_tag, s_r1_tag, s_r2_tag;
   logic [4:0]           s_rd;
   logic                 s_r1_busy, s_r2_busy;

   logic                 capture, dispatch_fire;
   logic                 cap_hit1, cap_hit2, st_hit1, st_hit2;
   logic [XLEN-1:0]      cap_val1, cap_val2, st_val1, st_val2;
   logic [XLEN-1:0]      r1_v_n, r2_v_n;
   logic                 r1_busy_n, r2_busy_n;
   logic [ROB_IDX_W-1:0] r1_tag_n, r2_tag_n;

   assign dispatch_fire = stage_valid && !flush && !rst && !(|(s_sel & disp.rs_full));
   assign in_ready      = !rst && !flush && !rob_full && (!stage_valid || dispatch_fire);
   assign capture       = in_valid && in_ready;

   assign rob_alloc  = capture;
   assign rf_ren_we  = capture && in_rd_we && (in_rd != 5'd0);
   assign rf_ren_rd  = rst ? 5'd0 : in_rd;
   assign rf_ren_tag = rst ? '0 : rob_alloc_tag;

   rename_dispatch_stage_cdb_match #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .NUM_CDB(NUM_CDB)) u_cap1 (
      .tag(rf_r1_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .hit(cap_hit1), .value(cap_val1));
   rename_dispatch_stage_cdb_match #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .NUM_CDB(NUM_CDB)) u_cap2 (
      .tag(rf_r2_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .hit(cap_hit2), .value(cap_val2));
   rename_dispatch_stage_cdb_match #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .NUM_CDB(NUM_CDB)) u_st1 (
      .tag(s_r1_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .hit(st_hit1), .value(st_val1));
   rename_dispatch_stage_cdb_match #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .NUM_CDB(NUM_CDB)) u_st2 (
      .tag(s_r2_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .hit(st_hit2), .value(st_val2));

   // Capture-time operand resolution: alt value, x0, regfile, ROB, CDB, else pending.
   always_comb begin
      r1_v_n    = in_op1_alt;
      r1_busy_n = 1'b0;
      r1_tag_n  = '0;
      if (in_rs1_use) begin
         if (in_rs1 == 5'd0)    r1_v_n = '0;
         else if (rf_r1_ready)  r1_v_n = rf_r1_v;
         else if (rob_r1_ready) r1_v_n = rob_r1_v;
         else if (cap_hit1)     r1_v_n = cap_val1;
         else begin
            r1_v_n    = '0;
            r1_busy_n = 1'b1;
            r1_tag_n  = rf_r1_tag;
         end
      end
   end

   always_comb begin
      r2_v_n    = in_op2_alt;
      r2_busy_n = 1'b0;
      r2_tag_n  = '0;
      if (in_rs2_use) begin
         if (in_rs2 == 5'd0)    r2_v_n = '0;
         else if (rf_r2_ready)  r2_v_n = rf_r2_v;
         else if (rob_r2_ready) r2_v_n = rob_r2_v;
         else if (cap_hit2)     r2_v_n = cap_val2;
         else begin
            r2_v_n    = '0;
            r2_busy_n = 1'b1;
            r2_tag_n  = rf_r2_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_valid <= 1'b0;
         s_pc        <= '0;
         s_imm       <= '0;
         s_ctrl      <= '0;
         s_sel       <= '0;
         s_rob_tag   <= '0;
         s_rd        <= '0;
         s_r1_v      <= '0;
         s_r2_v      <= '0;
         s_r1_busy   <= 1'b0;
         s_r2_busy   <= 1'b0;
         s_r1_tag    <= '0;
         s_r2_tag    <= '0;
      end else if (flush) begin
         stage_valid <= 1'b0;
      end else if (capture) begin
         stage_valid <= 1'b1;
         s_pc        <= in_pc;
         s_imm       <= in_imm;
         s_ctrl      <= in_ctrl;
         s_sel       <= in_fu_sel;
         s_rob_tag   <= rob_alloc_tag;
         s_rd        <= in_rd;
         s_r1_v      <= r1_v_n;
         s_r2_v      <= r2_v_n;
         s_r1_busy   <= r1_busy_n;
         s_r2_busy   <= r2_busy_n;
         s_r1_tag    <= r1_tag_n;
         s_r2_tag    <= r2_tag_n;
      end else begin
         if (dispatch_fire) stage_valid <= 1'b0;
         if (s_r1_busy && st_hit1) begin
            s_r1_v    <= st_val1;
            s_r1_busy <= 1'b0;
         end
         if (s_r2_busy && st_hit2) begin
            s_r2_v    <= st_val2;
            s_r2_busy <= 1'b0;
         end
      end
   end

   // Payload forwards a same-cycle CDB hit so an operand broadcast in the
   // dispatch cycle leaves resolved.
   assign disp.rs_dispatch = dispatch_fire ? s_sel : '0;
   assign disp.d_pc        = rst ? '0 : s_pc;
   assign disp.d_imm       = rst ? '0 : s_imm;
   assign disp.d_ctrl      = rst ? '0 : s_ctrl;
   assign disp.d_rob_tag   = rst ? '0 : s_rob_tag;
   assign disp.d_rd        = rst ? '0 : s_rd;
   assign disp.d_r1_v      = rst ? '0 : ((s_r1_busy && st_hit1) ? st_val1 : s_r1_v);
   assign disp.d_r2_v      = rst ? '0 : ((s_r2_busy && st_hit2) ? st_val2 : s_r2_v);
   assign disp.d_r1_busy   = !rst && s_r1_busy && !st_hit1;
   assign disp.d_r2_busy   = !rst && s_r2_busy && !st_hit2;
   assign disp.d_r1_tag    = rst ? '0 : s_r1_tag;
   assign disp.d_r2_tag    = rst ? '0 : s_r2_tag;

`ifdef DISPATCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_dispatched <= '0;
         perf_stall_rob  <= '0;
         perf_stall_rs   <= '0;
      end else begin
         if (dispatch_fire)                          perf_dispatched <= sat_inc(perf_dispatched);
         if (in_valid && rob_full)                   perf_stall_rob  <= sat_inc(perf_stall_rob);
         if (stage_valid && !dispatch_fire && !flush) perf_stall_rs  <= sat_inc(perf_stall_rs);
      end
   end
`endif

   a_fu_sel_onehot: assert property (@(posedge clk) disable iff (rst) in_valid |-> $onehot(in_fu_sel));

endmodule

// File: tb/tb_rename_dispatch_stage.sv
module tb_rename_dispatch_stage;
   import rename_dispatch_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic [31:0] in_pc, in_imm, in_ctrl, in_op1_alt, in_op2_alt;
   logic [3:0]  in_fu_sel;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic        in_rd_we, in_rs1_use, in_rs2_use;
   logic [31:0] rf_r1_v, rf_r2_v, rob_r1_v, rob_r2_v;
   logic        rf_r1_ready, rf_r2_ready, rob_r1_ready, rob_r2_ready, rob_full;
   logic [3:0]  rf_r1_tag, rf_r2_tag, rob_alloc_tag, rf_ren_tag;
   logic        rob_alloc, rf_ren_we;
   logic [4:0]  rf_ren_rd;
   logic [3:0]  cdb_valid;
   logic [15:0] cdb_tag;
   logic [127:0] cdb_value;
   cdb_t        cdb [4];
`ifdef DISPATCH_PERF_EN
   logic [31:0] perf_dispatched, perf_stall_rob, perf_stall_rs;
`endif

   int tests = 0;
   int fails = 0;

   rename_dispatch_stage_if #(.XLEN(32), .ROB_IDX_W(4), .NUM_RS(4), .CTRL_W(32)) disp ();

   rename_dispatch_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_imm(in_imm),
      .in_ctrl(in_ctrl), .in_fu_sel(in_fu_sel), .in_rd(in_rd), .in_rd_we(in_rd_we),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_use(in_rs1_use), .in_rs2_use(in_rs2_use),
      .in_op1_alt(in_op1_alt), .in_op2_alt(in_op2_alt),
      .rf_r1_v(rf_r1_v), .rf_r2_v(rf_r2_v), .rf_r1_ready(rf_r1_ready), .rf_r2_ready(rf_r2_ready),
      .rf_r1_tag(rf_r1_tag), .rf_r2_tag(rf_r2_tag),
      .rob_r1_v(rob_r1_v), .rob_r2_v(rob_r2_v), .rob_r1_ready(rob_r1_ready), .rob_r2_ready(rob_r2_ready),
      .rob_full(rob_full), .rob_alloc_tag(rob_alloc_tag), .rob_alloc(rob_alloc),
      .rf_ren_we(rf_ren_we), .rf_ren_rd(rf_ren_rd), .rf_ren_tag(rf_ren_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .disp(disp.master)
`ifdef DISPATCH_PERF_EN
      , .perf_dispatched(perf_dispatched), .perf_stall_rob(perf_stall_rob),
      .perf_stall_rs(perf_stall_rs)
`endif
   );

   always #5 clk = ~clk;

   always_comb begin
      cdb_valid = '0;
      cdb_tag   = '0;
      cdb_value = '0;
      for (int i = 0; i < 4; i++) begin
         cdb_valid[i]          = cdb[i].valid;
         cdb_tag[i*4 +: 4]     = cdb[i].tag;
         cdb_value[i*32 +: 32] = cdb[i].value;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_cdb();
      for (int i = 0; i < 4; i++) cdb[i] = '0;
   endtask

   initial begin
      clear_cdb();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1;
      in_pc = '0; in_imm = '0; in_ctrl = '0; in_fu_sel = 4'b0001;
      in_rd = 5'd1; in_rd_we = 1'b1; in_rs1 = '0; in_rs2 = '0;
      in_rs1_use = 1'b0; in_rs2_use = 1'b0; in_op1_alt = '0; in_op2_alt = '0;
      rf_r1_v = '0; rf_r2_v = '0; rf_r1_ready = 1'b1; rf_r2_ready = 1'b1;
      rf_r1_tag = '0; rf_r2_tag = '0; rob_r1_v = '0; rob_r2_v = '0;
      rob_r1_ready = 1'b0; rob_r2_ready = 1'b0; rob_full = 1'b0; rob_alloc_tag = 4'd9;
      disp.rs_full = '0;
      tick(); tick();
      chk("reset_in_ready", in_ready, 0);
      chk("reset_rob_alloc", rob_alloc, 0);
      chk("reset_ren_we", rf_ren_we, 0);
      chk("reset_dispatch", disp.rs_dispatch, 0);

      // Simple regfile-ready source plus alt operand
      rst = 1'b0;
      in_pc = 32'h100; in_imm = 32'h4; in_ctrl = 32'hC0DE; in_fu_sel = 4'b0001;
      in_rd = 5'd1; in_rs1 = 5'd5; in_rs1_use = 1'b1; rf_r1_v = 32'h10;
      in_rs2_use = 1'b0; in_op2_alt = 32'h4; rob_alloc_tag = 4'd2;
      #1;
      chk("t1_in_ready", in_ready, 1);
      chk("t1_rob_alloc", rob_alloc, 1);
      chk("t1_ren_we", rf_ren_we, 1);
      chk("t1_ren_tag", rf_ren_tag, 2);
      chk("t1_no_disp_yet", disp.rs_dispatch, 0);
      tick();
      in_valid = 1'b0;
      #1;
      chk("t1_dispatch", disp.rs_dispatch, 4'b0001);
      chk("t1_r1_v", disp.d_r1_v, 32'h10);
      chk("t1_r2_v", disp.d_r2_v, 32'h4);
      chk("t1_busy", {disp.d_r1_busy, disp.d_r2_busy}, 0);
      chk("t1_rob_tag", disp.d_rob_tag, 2);
      chk("t1_pc", disp.d_pc, 32'h100);
      chk("t1_ctrl", disp.d_ctrl, 32'hC0DE);
      tick();

      // Pending source woken by CDB while the RS is full
      in_valid = 1'b1; in_rs1 = 5'd6; rf_r1_ready = 1'b0; rf_r1_tag = 4'd3;
      in_rs2_use = 1'b0; in_op2_alt = '0; in_rd = 5'd2; rob_alloc_tag = 4'd5;
      disp.rs_full = 4'b0001;
      #1;
      chk("t2_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("t2_stall", disp.rs_dispatch, 0);
      chk("t2_busy", disp.d_r1_busy, 1);
      chk("t2_tag", disp.d_r1_tag, 3);
      chk("t2_in_ready_stalled", in_ready, 0);
      tick();
      cdb[0] = '{valid: 1'b1, tag: 4'd9, value: 32'h55};
      cdb[2] = '{valid: 1'b1, tag: 4'd3, value: 32'hAB};
      #1;
      chk("t2_fwd_busy", disp.d_r1_busy, 0);
      chk("t2_fwd_v", disp.d_r1_v, 32'hAB);
      chk("t2_still_full", disp.rs_dispatch, 0);
      tick();
      clear_cdb();
      disp.rs_full = '0;
      #1;
      chk("t2_dispatch", disp.rs_dispatch, 4'b0001);
      chk("t2_r1_v", disp.d_r1_v, 32'hAB);
      chk("t2_r1_busy", disp.d_r1_busy, 0);
      chk("t2_rob_tag", disp.d_rob_tag, 5);
      tick();

      // Same-cycle forward in the dispatch cycle, lowest CDB port wins
      in_valid = 1'b1; rf_r1_tag = 4'd7; in_fu_sel = 4'b0010; rob_alloc_tag = 4'd6;
      tick();
      in_valid = 1'b0;
      cdb[0] = '{valid: 1'b1, tag: 4'd7, value: 32'h77};
      cdb[3] = '{valid: 1'b1, tag: 4'd7, value: 32'h99};
      #1;
      chk("t3_dispatch", disp.rs_dispatch, 4'b0010);
      chk("t3_busy", disp.d_r1_busy, 0);
      chk("t3_v", disp.d_r1_v, 32'h77);
      tick();
      clear_cdb();

      // Back-to-back: rs1 = x0 while the regfile returns garbage
      in_valid = 1'b1; in_fu_sel = 4'b0001; in_rs1 = 5'd0; rf_r1_ready = 1'b1;
      rf_r1_v = 32'hDEAD; in_pc = 32'h200; rob_alloc_tag = 4'd1;
      #1;
      chk("t4a_ready", in_ready, 1);
      chk("t4a_alloc", rob_alloc, 1);
      chk("t4a_no_disp", disp.rs_dispatch, 0);
      tick();
      in_pc = 32'h204; rob_alloc_tag = 4'd2;
      #1;
      chk("t4b_ready", in_ready, 1);
      chk("t4b_alloc", rob_alloc, 1);
      chk("t4b_disp", disp.rs_dispatch, 4'b0001);
      chk("t4b_pc", disp.d_pc, 32'h200);
      tick();
      in_pc = 32'h208; rob_alloc_tag = 4'd3;
      #1;
      chk("t4c_ready", in_ready, 1);
      chk("t4c_alloc", rob_alloc, 1);
      chk("t4c_pc", disp.d_pc, 32'h204);
      tick();
      in_valid = 1'b0;
      #1;
      chk("t4d_disp", disp.rs_dispatch, 4'b0001);
      chk("t4d_pc", disp.d_pc, 32'h208);
      chk("t4d_tag", disp.d_rob_tag, 3);
      chk("t4d_x0", disp.d_r1_v, 0);
      tick();
      chk("t4e_empty", disp.rs_dispatch, 0);

      // ROB full blocks intake; flush squashes a staged entry
      in_valid = 1'b1; rob_full = 1'b1; in_rd = 5'd4;
      #1;
      chk("t5_rob_full_ready", in_ready, 0);
      chk("t5_rob_full_ren", rf_ren_we, 0);
      chk("t5_rob_full_alloc", rob_alloc, 0);
      tick();
      rob_full = 1'b0; disp.rs_full = 4'b0001;
      #1;
      chk("t5_empty", disp.rs_dispatch, 0);
      tick();
      in_valid = 1'b0; flush = 1'b1;
      #1;
      chk("t5_flush_disp", disp.rs_dispatch, 0);
      chk("t5_flush_ready", in_ready, 0);
      tick();
      flush = 1'b0; disp.rs_full = '0;
      #1;
      chk("t5_after_flush", disp.rs_dispatch, 0);
      tick();

      // Reset mid-stall discards the staged entry
      in_valid = 1'b1; in_pc = 32'h300; rob_alloc_tag = 4'd8; disp.rs_full = 4'b0001;
      tick();
      in_valid = 1'b0;
      #1;
      chk("t6_staged_pc", disp.d_pc, 32'h300);
      rst = 1'b1;
      tick();
      rst = 1'b0; disp.rs_full = '0;
      #1;
      chk("t6_rst_pc", disp.d_pc, 0);
      chk("t6_rst_disp", disp.rs_dispatch, 0);
      chk("t6_rst_tag", disp.d_rob_tag, 0);

      // rd = x0 never renames; ROB-ready and capture-time CDB sources
      in_valid = 1'b1; in_rd = 5'd0; in_rd_we = 1'b1; rob_alloc_tag = 4'd4;
      in_rs1 = 5'd7; rf_r1_ready = 1'b0; rob_r1_ready = 1'b1; rob_r1_v = 32'h1234;
      in_rs2 = 5'd8; in_rs2_use = 1'b1; rf_r2_ready = 1'b0; rf_r2_tag = 4'd8;
      rob_r2_ready = 1'b0;
      cdb[1] = '{valid: 1'b1, tag: 4'd8, value: 32'h88};
      #1;
      chk("t7_ren_we_x0", rf_ren_we, 0);
      chk("t7_alloc", rob_alloc, 1);
      tick();
      in_valid = 1'b0;
      clear_cdb();
      #1;
      chk("t7_disp", disp.rs_dispatch, 4'b0001);
      chk("t7_r1_rob", disp.d_r1_v, 32'h1234);
      chk("t7_r2_cdb", disp.d_r2_v, 32'h88);
      chk("t7_r2_busy", disp.d_r2_busy, 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/rename_dispatch_stage.md
Name: rename_dispatch_stage

Overview:
- Parametrised successor to the single-cycle rename/dispatch logic. Renames one decoded instruction per cycle against the regfile and the ROB, with NUM_CDB-wide CDB forwarding.
- Holds the renamed instruction in a one-entry staging register that keeps snooping the CDB while stalled.
- Dispatches to one of NUM_RS reservation stations through a one-hot valid/full handshake.
- Sits between the instruction queue/decode and the RS/ROB.

Parameters:
XLEN, 32, datapath width
ROB_IDX_W, 4, ROB tag width
NUM_CDB, 4, CDB broadcast ports
NUM_RS, 4, reservation-station channels
CTRL_W, 32, opaque control payload width (aluop/cmpop/mulop/funct3/opcode), passed through

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  squash staged entry; block intake this cycle
in_valid  in  1  decoded instruction present
in_ready  out  1  instruction accepted on in_valid&&in_ready
in_pc  in  XLEN  instruction PC
in_imm  in  XLEN  immediate
in_ctrl  in  CTRL_W  control payload
in_fu_sel  in  NUM_RS  one-hot target RS
in_rd  in  5  destination arch reg
in_rd_we  in  1  instruction writes rd
in_rs1/in_rs2  in  5 each  source arch regs
in_rs1_use/in_rs2_use  in  1 each  source is a register
in_op1_alt/in_op2_alt  in  XLEN each  operand value when the source is not a register (pc, imm, 4, 0 chosen by decode)
rf_r1_v/rf_r2_v  in  XLEN each  regfile value
rf_r1_ready/rf_r2_ready  in  1 each  regfile not busy
rf_r1_tag/rf_r2_tag  in  ROB_IDX_W each  producer tag when busy
rob_r1_v/rob_r2_v  in  XLEN each  ROB value for producer tag
rob_r1_ready/rob_r2_ready  in  1 each  ROB entry completed
rob_full  in  1  ROB cannot allocate
rob_alloc_tag  in  ROB_IDX_W  tag granted on allocation
rob_alloc  out  1  allocate ROB entry (equals capture)
rf_ren_we  out  1  write rename table (capture && in_rd_we && in_rd!=0)
rf_ren_rd  out  5  in_rd
rf_ren_tag  out  ROB_IDX_W  rob_alloc_tag
cdb_valid  in  NUM_CDB  broadcast valid
cdb_tag  in  NUM_CDB*ROB_IDX_W  broadcast tags
cdb_value  in  NUM_CDB*XLEN  broadcast values
rs_full  in  NUM_RS  RS cannot accept
rs_dispatch  out  NUM_RS  one-hot write strobe
d_pc, d_imm  out  XLEN each  staged payload
d_ctrl  out  CTRL_W  staged control payload
d_rob_tag  out  ROB_IDX_W  staged ROB tag
d_rd  out  5  staged destination
d_r1_v/d_r2_v  out  XLEN each  operand values
d_r1_busy/d_r2_busy  out  1 each  operand still pending
d_r1_tag/d_r2_tag  out  ROB_IDX_W each  pending producer tags

Behaviour:
- Capture = in_valid && in_ready.
- in_ready = !flush && !rob_full && (!stage_valid || dispatch_fire).
- dispatch_fire = stage_valid && !flush && !(|(sel & rs_full)).
- Operand resolution at capture, per source, in priority order:
  - use=0: value = op_alt, busy = 0.
  - rs = x0: value = 0, busy = 0.
  - rf ready: value = rf value.
  - ROB ready: value = ROB value.
  - CDB match (cdb_valid[i] && tag match; lowest i wins): value = cdb value.
  - Otherwise: busy = 1, tag = rf tag.
- While staged, each cycle: a busy operand whose tag matches a valid CDB port takes that value and clears busy (registered).
- Outputs forward the same-cycle CDB match combinationally, so an operand broadcast in the dispatch cycle leaves as busy=0.
- rs_dispatch = dispatch_fire ? sel : 0. Payload is presented every cycle but meaningful only under rs_dispatch.
- Dispatch and capture in the same cycle: the stage is refilled, no bubble. Latency is 1 cycle input to dispatch when the RS is free.
- Each instruction dispatches exactly once; the stage clears on fire unless refilled.
- in_fu_sel == 0 or multi-hot is illegal (assertion).
- flush: stage_valid <= 0; no capture, allocation, rename write or dispatch that cycle.
- Reset: stage_valid = 0. All outputs 0, including in_ready = 0 during reset. Reset mid-stall discards the staged entry.

Optional Feature:
DISPATCH_PERF_EN:
- With the macro: adds outputs perf_dispatched, perf_stall_rob and perf_stall_rs (32-bit each, saturating, cleared by rst).
  - perf_dispatched counts fires.
  - perf_stall_rob counts in_valid && rob_full cycles.
  - perf_stall_rs counts stage_valid && !dispatch_fire && !flush cycles.
- Without it: the ports and counters are absent.

Decomposition:
- rv32i_types holds ROB_IDX_W, NUM_CDB and the cdb_t typedef (valid, tag, value).
- Sub-module cdb_match: one tag against NUM_CDB ports, outputs hit and value with lowest index winning. Instantiated for capture-time and staged-time lookup of both operands.

Test Plan:
- rs1=x5 rf-ready 0x10, rs2 unused alt=0x4, sel=0001 → next cycle rs_dispatch=0001, d_r1_v=0x10, d_r2_v=4, both busy=0.
- rs1 busy tag 3, ROB not ready; cdb_valid[2] tag 3 value 0xAB two cycles later while rs_full[0]=1 → dispatch after full drops, d_r1_v=0xAB, busy=0.
- Staged busy tag 7 and CDB tag 7 in the dispatch cycle → same-cycle forward, d_r1_busy=0.
- Back-to-back three instructions, RS free → one dispatch per cycle, in_ready stays 1, rob_alloc ×3.
- rob_full=1 with in_valid → in_ready=0, no rf_ren_we; flush while staged → no dispatch, stage empty next cycle.
- rst asserted with staged entry → all outputs 0 next cycle; in_rd=0 with in_rd_we=1 → rf_ren_we=0.
